// File: rtl/disc_writer_pkg.sv
// rtl/disc_writer_pkg.sv - Stream-format constants and FSM encoding shared by disc reader and writer.
package disc_writer_pkg;

  localparam int STREAM_BITS = 8;
  localparam int STREAM_FLAG_BIT = STREAM_BITS - 1;
  localparam logic [STREAM_BITS-1:0] OVERFLOW_CODE = '1;
  localparam int OVERFLOW_TICKS = 127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_COUNT,
    ST_INDEX_WAIT,
    ST_DRAIN,
    ST_FINISHED,
    ST_ABORTED
  } state_t;

endpackage

// File: rtl/disc_write_pulse_gen.sv
// rtl/disc_write_pulse_gen.sv - Retriggerable one-shot producing the write-data pulse.
module disc_write_pulse_gen #(
  parameter int PULSE_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  input  logic clear,
  output logic pulse
);

  localparam int WW = $clog2(PULSE_WIDTH + 1);
  localparam logic [WW-1:0] W_LOAD = WW'(PULSE_WIDTH);
  localparam logic [WW-1:0] W_ONE = WW'(1);

  logic [WW-1:0] remaining;

  // A fire while already high reloads the width, so overlapping pulses merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= '0;
    end else if (fire) begin
      remaining <= W_LOAD;
    end else if (remaining != '0) begin
      remaining <= remaining - W_ONE;
    end
  end

  assign pulse = (remaining != '0);

endmodule

// File: rtl/disc_writer.sv
// rtl/disc_writer.sv - Replays acquisition-RAM timing bytes as flux write pulses.
module disc_writer
  import disc_writer_pkg::*;
#(
  parameter int BITS = 8,
  parameter int ADDR_BITS = 19,
  parameter int PULSE_WIDTH = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 CLKEN,
  input  logic                 RUN,
  input  logic [ADDR_BITS-1:0] LENGTH,
  output logic [ADDR_BITS-1:0] ADDR,
  input  logic [BITS-1:0]      DATA,
  input  logic                 FD_INDEX_IN,
  output logic                 FD_WRDATA_OUT,
  output logic                 FD_WRGATE_OUT,
  output logic                 DONE,
  output logic                 UNDERRUN
);

  localparam int CW = BITS - 1;
  localparam logic [CW-1:0] OVF_LAST = CW'(OVERFLOW_TICKS - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);

  state_t state, state_next;
  logic run_q, idx_s, idx_d, idx_edge;
  logic [ADDR_BITS-1:0] len, act_idx;
  logic [BITS-1:0] act_byte, hold_byte;
  logic act_valid, hold_valid;
  logic fetch_p1, fetch_p2;
  logic [CW-1:0] cnt, act_limit;
  logic boundary, fire, clear, take_hold, last_byte, more_to_fetch, start;

  function automatic logic is_index(input logic [BITS-1:0] b);
    return b[BITS-1] && (b != {BITS{1'b1}});
  endfunction

  assign idx_edge = idx_s & ~idx_d;
  assign act_limit = (act_byte == {BITS{1'b1}}) ? OVF_LAST : act_byte[CW-1:0];
  assign last_byte = (act_idx == len - A_ONE);
  assign more_to_fetch = ((ADDR + A_ONE) < len);
  assign start = (state == ST_IDLE) && RUN && !run_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    boundary = 1'b0;
    fire = 1'b0;
    clear = 1'b0;
    take_hold = 1'b0;
    if (!RUN) begin
      state_next = ST_IDLE;
      clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (!run_q) state_next = (LENGTH == '0) ? ST_FINISHED : ST_PRIME;
        ST_PRIME: begin
          if (act_valid && !fetch_p1 && !fetch_p2)
            state_next = is_index(act_byte) ? ST_INDEX_WAIT : ST_COUNT;
        end
        ST_COUNT: begin
          boundary = CLKEN && (cnt == act_limit);
          fire = boundary && !act_byte[BITS-1];
        end
        ST_INDEX_WAIT: boundary = idx_edge;
        ST_DRAIN: if (!FD_WRDATA_OUT) state_next = ST_FINISHED;
        default: ;
      endcase
      if (boundary) begin
        if (last_byte) begin
          state_next = ST_DRAIN;
        end else if (!hold_valid) begin
          state_next = ST_ABORTED;
          clear = 1'b1;
        end else begin
          take_hold = 1'b1;
          state_next = is_index(hold_byte) ? ST_INDEX_WAIT : ST_COUNT;
        end
      end
    end
  end

  // RAM returns DATA one CLOCK after it registers ADDR, so a fetch lands two edges after issue.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      run_q <= 1'b0;
      idx_s <= 1'b0;
      idx_d <= 1'b0;
      ADDR <= '0;
      len <= '0;
      act_idx <= '0;
      act_byte <= '0;
      hold_byte <= '0;
      act_valid <= 1'b0;
      hold_valid <= 1'b0;
      fetch_p1 <= 1'b0;
      fetch_p2 <= 1'b0;
      cnt <= '0;
      FD_WRGATE_OUT <= 1'b0;
      DONE <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      run_q <= RUN;
      idx_s <= FD_INDEX_IN;
      idx_d <= idx_s;
      fetch_p1 <= 1'b0;
      fetch_p2 <= fetch_p1;
      if (start) begin
        ADDR <= '0;
        len <= LENGTH;
        act_idx <= '0;
        act_valid <= 1'b0;
        hold_valid <= 1'b0;
        cnt <= '0;
        fetch_p1 <= (LENGTH != '0);
      end
      if (state == ST_PRIME && fetch_p1 && ADDR == '0 && more_to_fetch) begin
        ADDR <= A_ONE;
        fetch_p1 <= 1'b1;
      end
      if (state == ST_COUNT && CLKEN && !boundary) cnt <= cnt + C_ONE;
      if (boundary) cnt <= '0;
      if (take_hold) begin
        act_byte <= hold_byte;
        act_idx <= act_idx + A_ONE;
        hold_valid <= 1'b0;
        if (more_to_fetch) begin
          ADDR <= ADDR + A_ONE;
          fetch_p1 <= 1'b1;
        end
      end
      if (fetch_p2) begin
        if (!act_valid) begin
          act_byte <= DATA;
          act_valid <= 1'b1;
        end else begin
          hold_byte <= DATA;
          hold_valid <= 1'b1;
        end
      end
      FD_WRGATE_OUT <= (state_next == ST_COUNT) || (state_next == ST_INDEX_WAIT) ||
                       (state_next == ST_DRAIN);
      DONE <= (state_next == ST_FINISHED);
      UNDERRUN <= (state_next == ST_ABORTED);
    end
  end

  disc_write_pulse_gen #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_pulse (
    .clk  (CLOCK),
    .rst  (RESET),
    .fire (fire),
    .clear(clear),
    .pulse(FD_WRDATA_OUT)
  );

endmodule
